// File: rtl/scam_blk_ctrl.sv
// SCA block controller: free-running block-phase counter, per-phase SCA write-select
// decodes, and per-block LCT occupancy history with a saturating LCT count.
module scam_blk_ctrl #(
   parameter int STATE_W = 4,
   parameter int NHIST   = 2,
   parameter int TMR     = 0
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               SYNC,
   input  logic               LCTDLY,
   input  logic               DONE,
   input  logic               NOGTRG,
   input  logic               NODATA,
   input  logic               FB_NODATA,
   input  logic               SCND_BLK,
   input  logic               SCND_SHARED,
   input  logic               DLSCAFULL,
   input  logic               DSCAFULL,
   output logic [STATE_W-1:0] STATE,
   output logic               SELA,
   output logic               SELB,
   output logic               SELC,
   output logic               SELD,
   output logic               NOLCT,
   output logic               WRENA,
   output logic               LCTYENA,
   output logic               PREBLKEND,
   output logic               NBSEL,
   output logic               ENAREG,
   output logic [STATE_W-1:0] LCT_CNT,
   output logic               LCT_OVF
);

   localparam logic [STATE_W-1:0] PH_E   = '1;
   localparam logic [STATE_W-1:0] PH_NB  = PH_E - 1'b1;
   localparam logic [STATE_W-1:0] PH_P   = PH_E - 2'd2;
   localparam logic [STATE_W-1:0] CNT_MX = '1;

   // Out-of-range parameters leave an empty marker scope; TMR has no functional effect.
   if (STATE_W < 4 || STATE_W > 6 || NHIST < 1 || NHIST > 8 || TMR < 0) begin : g_illegal_params
   end

   logic [STATE_W-1:0] state_q, state_d;
   logic [STATE_W-1:0] cnt_q, cnt_d;
   logic [NHIST-1:0]   hist_q, hist_d;
   logic [STATE_W-1:0] lct_cnt_q, lct_cnt_d;
   logic               ovf_q, ovf_d;

   logic               cnt_sat;
   logic [STATE_W-1:0] cnt_inc;
   logic [NHIST:0]     hist_sh;
   logic               llct;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= '0;
         cnt_q     <= '0;
         hist_q    <= '0;
         lct_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hist_q    <= hist_d;
         lct_cnt_q <= lct_cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      state_d   = SYNC ? '0 : state_q + 1'b1;
      cnt_sat   = (cnt_q == CNT_MX);
      cnt_inc   = cnt_sat ? cnt_q : cnt_q + 1'b1;
      hist_sh   = {hist_q, (cnt_q != '0) | LCTDLY};
      cnt_d     = cnt_q;
      hist_d    = hist_q;
      lct_cnt_d = lct_cnt_q;
      ovf_d     = ovf_q;
      // An LCT on the closing cycle belongs to the ending block.
      if (PREBLKEND) begin
         lct_cnt_d = LCTDLY ? cnt_inc : cnt_q;
         hist_d    = hist_sh[NHIST-1:0];
         cnt_d     = '0;
      end else if (LCTDLY) begin
         cnt_d = cnt_inc;
      end
      if (LCTDLY && cnt_sat) ovf_d = 1'b1;
      if (SYNC) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end
   end

   assign llct      = |hist_q;
   assign STATE     = state_q;
   assign PREBLKEND = (state_q == PH_P);
   assign NBSEL     = (state_q == PH_NB);
   assign ENAREG    = (state_q == PH_E);
   assign SELA      = (state_q == STATE_W'(5));
   assign SELB      = NOGTRG & ~DLSCAFULL & (state_q == STATE_W'(3));
   assign SELC      = DONE & SCND_BLK & ~SCND_SHARED & ~NODATA & (state_q == STATE_W'(2));
   assign SELD      = DONE & SCND_BLK & ~FB_NODATA & (state_q == STATE_W'(4));
   assign LCTYENA   = llct & NBSEL;
   assign NOLCT     = ~llct & ~DSCAFULL & NBSEL;
   assign WRENA     = SELA | SELB | SELC | SELD | NOLCT;
   assign LCT_CNT   = lct_cnt_q;
   assign LCT_OVF   = ovf_q;

endmodule

// File: tb/tb_scam_blk_ctrl.sv
// Bench for scam_blk_ctrl: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a block-level behavioural model.
module tb_scam_blk_ctrl;
   localparam int SW   = 4;
   localparam int NH   = 2;
   localparam int L    = 1 << SW;
   localparam int CMAX = L - 1;

   logic CLK = 1'b0, RST = 1'b1, SYNC = 1'b0, LCTDLY = 1'b0;
   logic DONE = 0, NOGTRG = 0, NODATA = 0, FB_NODATA = 0, SCND_BLK = 0, SCND_SHARED = 0;
   logic DLSCAFULL = 0, DSCAFULL = 0;
   logic [SW-1:0] STATE, LCT_CNT;
   logic SELA, SELB, SELC, SELD, NOLCT, WRENA, LCTYENA, PREBLKEND, NBSEL, ENAREG, LCT_OVF;

   scam_blk_ctrl #(.STATE_W(SW), .NHIST(NH), .TMR(0)) dut (
      .CLK(CLK), .RST(RST), .SYNC(SYNC), .LCTDLY(LCTDLY), .DONE(DONE), .NOGTRG(NOGTRG),
      .NODATA(NODATA), .FB_NODATA(FB_NODATA), .SCND_BLK(SCND_BLK), .SCND_SHARED(SCND_SHARED),
      .DLSCAFULL(DLSCAFULL), .DSCAFULL(DSCAFULL), .STATE(STATE), .SELA(SELA), .SELB(SELB),
      .SELC(SELC), .SELD(SELD), .NOLCT(NOLCT), .WRENA(WRENA), .LCTYENA(LCTYENA),
      .PREBLKEND(PREBLKEND), .NBSEL(NBSEL), .ENAREG(ENAREG), .LCT_CNT(LCT_CNT), .LCT_OVF(LCT_OVF)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0, n_fail = 0;

   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: phase number, raw (unsaturated) LCT count of the open block, occupancy of past blocks.
   int m_phase, m_n, m_lct_cnt;
   bit m_ovf;
   bit m_hist[$];

   function automatic void m_reset();
      m_phase = 0; m_n = 0; m_lct_cnt = 0; m_ovf = 0;
      m_hist = {};
      repeat (NH) m_hist.push_back(1'b0);
   endfunction

   function automatic void m_step();
      int total;
      if (m_phase == L - 3) begin
         total = m_n + int'(LCTDLY);
         m_lct_cnt = (total > CMAX) ? CMAX : total;
         if (total > CMAX) m_ovf = 1;
         m_hist.push_front(total > 0);
         void'(m_hist.pop_back());
         m_n = 0;
      end else begin
         m_n += int'(LCTDLY);
         if (m_n > CMAX) m_ovf = 1;
      end
      if (SYNC) begin
         m_n = 0; m_ovf = 0; m_phase = 0;
      end else m_phase = (m_phase + 1) % L;
   endfunction

   function automatic void m_compare();
      bit llct, sa, sb, sc, sd, nl, ly, pb, nb, en;
      llct = 0;
      foreach (m_hist[i]) llct |= m_hist[i];
      pb = (m_phase == L - 3); nb = (m_phase == L - 2); en = (m_phase == L - 1);
      sa = (m_phase == 5);
      sb = NOGTRG && !DLSCAFULL && m_phase == 3;
      sc = DONE && SCND_BLK && !SCND_SHARED && !NODATA && m_phase == 2;
      sd = DONE && SCND_BLK && !FB_NODATA && m_phase == 4;
      nl = !llct && !DSCAFULL && nb;
      ly = llct && nb;
      chk("STATE", int'(STATE), m_phase);
      chk("strobes", int'({SELA, SELB, SELC, SELD, NOLCT, WRENA, LCTYENA, PREBLKEND, NBSEL, ENAREG}),
          int'({sa, sb, sc, sd, nl, sa | sb | sc | sd | nl, ly, pb, nb, en}));
      chk("LCT_CNT", int'(LCT_CNT), m_lct_cnt);
      chk("LCT_OVF", int'(LCT_OVF), int'(m_ovf));
   endfunction

   // One clock: compare on the falling edge, advance the model on the rising edge.
   task automatic cycle();
      if (RST) m_reset();
      @(negedge CLK);
      m_compare();
      @(posedge CLK);
      if (RST) m_reset(); else m_step();
      #1;
   endtask

   task automatic go_to(int p);
      int n = 0;
      while (int'(STATE) != p && n < 40) begin
         cycle();
         n++;
      end
      if (n >= 40) begin
         n_fail++;
         $display("FAIL go_to: phase %0d not reached, STATE=%0d", p, STATE);
      end
   endtask

   initial begin
      m_reset();
      repeat (3) cycle();
      RST = 0;
      #1 chk("rst STATE", int'(STATE), 0);
      chk("rst WRENA", int'(WRENA), 0);
      // Free run through one block.
      for (int i = 0; i < L; i++) begin
         #1;
         chk("run STATE", int'(STATE), i);
         chk("run PREBLKEND", int'(PREBLKEND), int'(i == 13));
         chk("run ENAREG", int'(ENAREG), int'(i == 15));
         chk("run SELA", int'(SELA), int'(i == 5));
         cycle();
      end
      #1 chk("wrap STATE", int'(STATE), 0);

      // Single LCT seen for two blocks of history.
      go_to(7);
      LCTDLY = 1; cycle(); LCTDLY = 0;
      go_to(14);
      #1 chk("lct1 LCTYENA", int'(LCTYENA), 1);
      chk("lct1 LCT_CNT", int'(LCT_CNT), 1);
      cycle(); go_to(14);
      #1 chk("lct1 k+1 LCTYENA", int'(LCTYENA), 1);
      cycle(); go_to(14);
      #1 chk("lct1 k+2 NOLCT", int'(NOLCT), 1);
      chk("lct1 k+2 LCTYENA", int'(LCTYENA), 0);

      // LCT on the closing phase belongs to the ending block.
      cycle(); go_to(13);
      LCTDLY = 1; cycle(); LCTDLY = 0;
      #1 chk("bnd13 LCT_CNT", int'(LCT_CNT), 1);
      chk("bnd13 LCTYENA", int'(LCTYENA), 1);
      LCTDLY = 1; cycle(); LCTDLY = 0;
      go_to(14);
      #1 chk("bnd14 LCT_CNT", int'(LCT_CNT), 1);

      // Saturation and sticky overflow.
      LCTDLY = 1; repeat (16) cycle(); LCTDLY = 0;
      #1 chk("sat LCT_CNT", int'(LCT_CNT), 15);
      chk("sat LCT_OVF", int'(LCT_OVF), 1);
      go_to(9);
      #1 chk("sat sticky", int'(LCT_OVF), 1);
      SYNC = 1; cycle(); SYNC = 0;
      #1 chk("sync STATE", int'(STATE), 0);
      chk("sync LCT_OVF", int'(LCT_OVF), 0);
      chk("sync LCT_CNT kept", int'(LCT_CNT), 15);
      repeat (13) cycle();
      #1 chk("sync PREBLKEND", int'(PREBLKEND), 1);
      cycle();
      #1 chk("sync LCT_CNT", int'(LCT_CNT), 0);

      // Qualifiers.
      go_to(3);
      NOGTRG = 1;
      #1 chk("selb", int'({SELB, WRENA}), 3);
      DLSCAFULL = 1;
      #1 chk("selb full", int'(SELB), 0);
      NOGTRG = 0; DLSCAFULL = 0;
      go_to(2);
      DONE = 1; SCND_BLK = 1; SCND_SHARED = 1;
      #1 chk("selc shared", int'(SELC), 0);
      SCND_SHARED = 0;
      #1 chk("selc", int'(SELC), 1);
      DONE = 0; SCND_BLK = 0;
      go_to(14);
      DSCAFULL = 1;
      #1 chk("nolct full", int'(NOLCT), 0);
      DSCAFULL = 0;
      #1 chk("nolct", int'(NOLCT), 1);

      // Random traffic with bursty LCT density.
      begin
         int dens = 30;
         for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) dens = ($urandom_range(0, 2) == 0) ? 95 : $urandom_range(5, 40);
            LCTDLY      = $urandom_range(0, 99) < dens;
            SYNC        = $urandom_range(0, 59) == 0;
            RST         = $urandom_range(0, 699) == 0;
            DONE        = $urandom_range(0, 1) == 1;
            NOGTRG      = $urandom_range(0, 1) == 1;
            NODATA      = $urandom_range(0, 1) == 1;
            FB_NODATA   = $urandom_range(0, 1) == 1;
            SCND_BLK    = $urandom_range(0, 1) == 1;
            SCND_SHARED = $urandom_range(0, 1) == 1;
            DLSCAFULL   = $urandom_range(0, 1) == 1;
            DSCAFULL    = $urandom_range(0, 3) == 0;
            cycle();
         end
      end
      RST = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
